// File: rtl/pong_game_controller.sv
// pong_game_controller: match sequencer (IDLE/SERVE/PLAY/POINT/OVER) gating ball physics; ports clk, rst(active-low sync), frame_tick, start_btn, player_did_score -> physics_en, ball_reset, score_left/right, game_over, winner, state_dbg
module pong_game_controller #(
  parameter int WIN_SCORE          = 7,
  parameter int SERVE_DELAY_FRAMES = 60,
  parameter int SCORE_W            = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               frame_tick,
  input  logic               start_btn,
  input  logic [1:0]         player_did_score,
  output logic               physics_en,
  output logic               ball_reset,
  output logic [SCORE_W-1:0] score_left,
  output logic [SCORE_W-1:0] score_right,
  output logic               game_over,
  output logic               winner,
  output logic [2:0]         state_dbg
);
  localparam int CW = $clog2(SERVE_DELAY_FRAMES + 1);
  localparam logic [CW-1:0] DELAY = CW'(SERVE_DELAY_FRAMES);
  typedef enum logic [2:0] {IDLE = 3'd0, SERVE = 3'd1, PLAY = 3'd2, POINT = 3'd3, OVER = 3'd4} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [SCORE_W-1:0] score_l_q, score_l_d, score_r_q, score_r_d, inc;
  logic start_q, start_rise, scorer_q, scorer_d, winner_q, winner_d;
  always_comb begin
    start_rise = start_btn & ~start_q;
    inc = (scorer_q ? score_r_q : score_l_q) + SCORE_W'(1);
    state_d = state_q;
    cnt_d = cnt_q;
    scorer_d = scorer_q;
    winner_d = winner_q;
    score_l_d = score_l_q;
    score_r_d = score_r_q;
    case (state_q)
      IDLE: begin
        score_l_d = '0;
        score_r_d = '0;
        if (start_rise) begin
          state_d = SERVE;
          cnt_d = DELAY;
        end
      end
      SERVE: if (frame_tick) begin
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) state_d = PLAY;
      end
      PLAY: if (^player_did_score) begin
        scorer_d = player_did_score[1];
        state_d = POINT;
      end
      POINT: begin
        score_r_d = scorer_q ? inc : score_r_q;
        score_l_d = scorer_q ? score_l_q : inc;
        if (inc == SCORE_W'(WIN_SCORE)) begin
          state_d = OVER;
          winner_d = scorer_q;
        end else begin
          state_d = SERVE;
          cnt_d = DELAY;
        end
      end
      OVER: if (start_rise) begin
        score_l_d = '0;
        score_r_d = '0;
        winner_d = 1'b0;
        cnt_d = DELAY;
        state_d = SERVE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      start_q <= 1'b0;
      scorer_q <= 1'b0;
      winner_q <= 1'b0;
      score_l_q <= '0;
      score_r_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      start_q <= start_btn;
      scorer_q <= scorer_d;
      winner_q <= winner_d;
      score_l_q <= score_l_d;
      score_r_q <= score_r_d;
    end
  end
  assign physics_en = state_q == PLAY;
  assign ball_reset = state_q != PLAY;
  assign game_over = state_q == OVER;
  assign winner = winner_q;
  assign score_left = score_l_q;
  assign score_right = score_r_q;
  assign state_dbg = state_q;
endmodule

// File: tb/tb_pong_game_controller.sv
// tb_pong_game_controller: directed self-checking bench for pong_game_controller
module tb_pong_game_controller;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic frame_tick = 1'b0;
  logic start_btn = 1'b0;
  logic [1:0] player_did_score = 2'b00;
  logic physics_en, ball_reset, game_over, winner;
  logic [3:0] score_left, score_right;
  logic [2:0] state_dbg;
  int vectors = 0;
  int miscompares = 0;
  pong_game_controller #(.WIN_SCORE(7), .SERVE_DELAY_FRAMES(3), .SCORE_W(4)) dut (
    .clk(clk),
    .rst(rst),
    .frame_tick(frame_tick),
    .start_btn(start_btn),
    .player_did_score(player_did_score),
    .physics_en(physics_en),
    .ball_reset(ball_reset),
    .score_left(score_left),
    .score_right(score_right),
    .game_over(game_over),
    .winner(winner),
    .state_dbg(state_dbg)
  );
  always #5 clk = ~clk;
  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic chk_all(input string tag, input logic [2:0] st, input logic [3:0] sl, input logic [3:0] sr, input logic w);
    chk({tag, " state"}, state_dbg, st);
    chk({tag, " physics_en"}, physics_en, st == 3'd2);
    chk({tag, " ball_reset"}, ball_reset, st != 3'd2);
    chk({tag, " game_over"}, game_over, st == 3'd4);
    chk({tag, " score_left"}, score_left, sl);
    chk({tag, " score_right"}, score_right, sr);
    chk({tag, " winner"}, winner, w);
  endtask
  task automatic serve();
    frame_tick = 1'b1;
    cyc(3);
    frame_tick = 1'b0;
    chk("serve->play", state_dbg, 3'd2);
  endtask
  task automatic point(input logic [1:0] side);
    player_did_score = side;
    cyc(1);
    player_did_score = 2'b00;
    cyc(1);
  endtask
  initial begin
    cyc(2);
    chk_all("reset", 3'd0, 4'd0, 4'd0, 1'b0);
    rst = 1'b1;
    cyc(1);
    chk_all("idle", 3'd0, 4'd0, 4'd0, 1'b0);
    start_btn = 1'b1;
    cyc(1);
    chk_all("start", 3'd1, 4'd0, 4'd0, 1'b0);
    for (int i = 0; i < 2; i++) begin
      frame_tick = 1'b1;
      cyc(1);
      frame_tick = 1'b0;
      cyc(1);
      chk("serve early", state_dbg, 3'd1);
    end
    frame_tick = 1'b1;
    cyc(1);
    frame_tick = 1'b0;
    chk_all("third tick", 3'd2, 4'd0, 4'd0, 1'b0);
    frame_tick = 1'b1;
    cyc(1);
    frame_tick = 1'b0;
    chk("tick in play", state_dbg, 3'd2);
    player_did_score = 2'b11;
    cyc(2);
    player_did_score = 2'b00;
    chk_all("illegal strobe", 3'd2, 4'd0, 4'd0, 1'b0);
    player_did_score = 2'b10;
    cyc(1);
    chk_all("point latency", 3'd3, 4'd0, 4'd0, 1'b0);
    cyc(1);
    chk_all("point applied", 3'd1, 4'd0, 4'd1, 1'b0);
    cyc(2);
    player_did_score = 2'b00;
    chk_all("held strobe", 3'd1, 4'd0, 4'd1, 1'b0);
    start_btn = 1'b0;
    cyc(1);
    start_btn = 1'b1;
    cyc(1);
    chk("start in serve", state_dbg, 3'd1);
    serve();
    point(2'b01); serve();
    point(2'b01); serve();
    point(2'b01); serve();
    point(2'b10); serve();
    chk_all("rally 3-2", 3'd2, 4'd3, 4'd2, 1'b0);
    start_btn = 1'b0;
    rst = 1'b0;
    cyc(1);
    chk_all("reset mid-rally", 3'd0, 4'd0, 4'd0, 1'b0);
    rst = 1'b1;
    cyc(1);
    chk("idle after reset", state_dbg, 3'd0);
    start_btn = 1'b1;
    cyc(1);
    chk("restart serve", state_dbg, 3'd1);
    serve();
    for (int i = 0; i < 5; i++) begin
      point(2'b10);
      serve();
    end
    for (int i = 0; i < 6; i++) begin
      point(2'b01);
      serve();
    end
    chk_all("6-5", 3'd2, 4'd6, 4'd5, 1'b0);
    player_did_score = 2'b01;
    cyc(1);
    chk_all("match point", 3'd3, 4'd6, 4'd5, 1'b0);
    cyc(1);
    chk_all("left wins", 3'd4, 4'd7, 4'd5, 1'b0);
    frame_tick = 1'b1;
    player_did_score = 2'b10;
    cyc(3);
    frame_tick = 1'b0;
    player_did_score = 2'b00;
    chk_all("over frozen", 3'd4, 4'd7, 4'd5, 1'b0);
    start_btn = 1'b0;
    cyc(1);
    chk("over released", state_dbg, 3'd4);
    start_btn = 1'b1;
    cyc(1);
    chk_all("restart", 3'd1, 4'd0, 4'd0, 1'b0);
    serve();
    for (int i = 0; i < 6; i++) begin
      point(2'b10);
      serve();
    end
    point(2'b10);
    chk_all("right wins", 3'd4, 4'd0, 4'd7, 1'b1);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/pong_game_controller.md
# pong_game_controller

Match-level sequencer sitting directly downstream of the ball-physics stage: consumes its one-hot `player_did_score` strobe, keeps both players' scores, and gates the physics stage through serve, rally, point and game-over phases. Its `physics_en` and `ball_reset` outputs feed back into the physics/ball-position registers, so each rally starts from a centred ball after a fixed frame-count delay.

## Interface
- `WIN_SCORE`, default 7: points needed to win; must be ≥1 and < 2^`SCORE_W`.
- `SERVE_DELAY_FRAMES`, default 60: `frame_tick` pulses spent in SERVE before play resumes; must be ≥1.
- `SCORE_W`, default 4: score counter width.
- `clk` in 1: system clock.
- `rst` in 1: synchronous, active-low reset.
- `frame_tick` in 1: one-`clk`-wide pulse, once per video frame.
- `start_btn` in 1: start request. Level input, already synchronised upstream.
- `player_did_score` in 2: output of the physics stage.
  - 2'b01: point to left player.
  - 2'b10: point to right player.
  - 2'b00 or 2'b11: no point.
- `physics_en` out 1: high only in PLAY; enables the physics and ball-position update.
- `ball_reset` out 1: high in IDLE, SERVE, POINT and OVER; holds the ball at the centre.
- `score_left` out `SCORE_W`: left player's points.
- `score_right` out `SCORE_W`: right player's points.
- `game_over` out 1: high in OVER.
- `winner` out 1: 0 = left, 1 = right. Valid while `game_over` is high; otherwise 0.
- `state_dbg` out 3: encoding IDLE=0, SERVE=1, PLAY=2, POINT=3, OVER=4.

## Operation
- **Start edge.** `start_btn` is registered internally. `start_rise` = current high AND previous low.
- **IDLE:** scores held at 0. On `start_rise`, go to SERVE and load the serve counter with `SERVE_DELAY_FRAMES`.
- **SERVE:** each `frame_tick` decrements the serve counter. When a tick arrives with the counter at 1, go to PLAY. `player_did_score` is ignored.
- **PLAY:** `player_did_score` is sampled every cycle.
  - 2'b01 or 2'b10: latch the scorer, go to POINT.
  - 2'b11: treated as 2'b00 (no point, stay in PLAY).
- **POINT** (exactly one cycle):
  - Increment the latched player's score.
  - If the new value equals `WIN_SCORE`: go to OVER and set `winner`.
  - Otherwise: go to SERVE and reload the serve counter.
- **OVER:** scores and `winner` frozen. On `start_rise`: clear both scores, clear `winner`, reload the serve counter, go to SERVE. The first serve of the new game goes straight to SERVE, skipping IDLE.
- **Score arithmetic.** Scores never exceed `WIN_SCORE`; there is no wrap. Only one score changes per POINT.
- **Idle events.** `start_rise` in SERVE, PLAY or POINT has no effect. `frame_tick` outside SERVE has no effect.

## Timing
- **Reset** (`rst` low at a `clk` edge, any state, including mid-rally or mid-serve):
  - Next state IDLE.
  - `physics_en`=0, `ball_reset`=1, `score_left`=`score_right`=0.
  - `game_over`=0, `winner`=0, `state_dbg`=0.
  - Serve counter = 0; start edge register = 0.
- **Outputs** are decoded from registered state, so each changes in the cycle after its state transition.
- **Point latency.** `player_did_score` nonzero at edge N in PLAY:
  - `physics_en` falls and `ball_reset` rises after edge N; `state_dbg`=3.
  - Score increments after edge N+1, along with entry to SERVE or OVER.
- **Repeated strobes.** Because the strobe is ignored outside PLAY, a strobe held for several cycles scores exactly once.
- **Serve delay.** SERVE lasts exactly `SERVE_DELAY_FRAMES` `frame_tick` pulses. PLAY begins the cycle after the last counted tick.
- **Simultaneous inputs.** A `frame_tick` in the same cycle as the SERVE→PLAY transition is consumed by that transition.

## Test plan
- **Reset mid-rally.** Reach PLAY with score 3–2, then drive `rst`=0 for 1 cycle → next cycle `state_dbg`=0, both scores 0, `ball_reset`=1, `physics_en`=0.
- **Start and serve delay.** `SERVE_DELAY_FRAMES`=3, `start_btn` rises in IDLE → SERVE; PLAY (`physics_en`=1) begins the cycle after the 3rd `frame_tick`, not earlier. Holding `start_btn` high gives no second start.
- **Single point, held strobe.** In PLAY, hold `player_did_score`=2'b10 for 4 cycles → `score_right` goes 0→1 exactly once, `score_left` stays 0, state sequence PLAY→POINT→SERVE.
- **Illegal strobe.** In PLAY, `player_did_score`=2'b11 → no score change, state stays PLAY, `physics_en` stays 1.
- **Game over.** `WIN_SCORE`=7, left player reaches 7 while right has 5 → `game_over`=1, `winner`=0, scores frozen at 7/5, `physics_en`=0; further strobes and `frame_tick`s have no effect.
- **Restart.** In OVER, release then re-press `start_btn` → scores clear to 0/0, `game_over`=0, state SERVE (`state_dbg`=1) without passing through IDLE.
